// File: rtl/rom_bus_sequencer_if.sv
// Signal bundle between the 4004-style ROM bus sequencer, the ROM pads and the core.
// Handshake: instr_valid is a one-clock strobe with no ready; the core must take instr in X2.
interface rom_bus_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             halt;
  logic [11:0]      pc;
  logic [3:0]       rom_in;
  logic [3:0]       addr_nibble;
  logic             addr_oeb;
  logic             sync;
  logic [2:0]       phase;
  logic [7:0]       instr;
  logic             instr_valid;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  halt, pc, rom_in,
    output addr_nibble, addr_oeb, sync, phase, instr, instr_valid, cycle_count
  );

  modport slave (
    output halt, pc, rom_in,
    input  addr_nibble, addr_oeb, sync, phase, instr, instr_valid, cycle_count
  );
endinterface

// File: rtl/rom_bus_sequencer.sv
// 8-phase instruction cycle generator: drives the fetch address as three nibbles,
// captures two data nibbles and strobes the assembled opcode to the core in X2.
module rom_bus_sequencer #(
  parameter int CNT_W = 16
) (
  input logic               clock,
  input logic               reset,
  rom_bus_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
        M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
    } phase_e;

    phase_e           state_q, state_d;
    logic [11:0]      pc_q, pc_d;
    logic [3:0]       addr_q, addr_d;
    logic             oeb_q, oeb_d;
    logic             sync_q, sync_d;
    logic [3:0]       rom_q, hi_q;
    logic [7:0]       instr_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             wrap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= X3;
            pc_q    <= '0;
            addr_q  <= '0;
            oeb_q   <= 1'b1;
            sync_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            oeb_q   <= oeb_d;
            sync_q  <= sync_d;
        end
    end

    // Address outputs are computed from the next phase so they are registered
    // and valid for the whole phase they belong to.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap    = 1'b0;
        addr_d  = '0;
        oeb_d   = 1'b1;
        case (state_q)
            X3: begin
                if (!bus.halt) begin
                    state_d = A1;
                    pc_d    = bus.pc;
                    wrap    = 1'b1;
                end
            end
            default: state_d = phase_e'(state_q + 3'd1);
        endcase
        case (state_d)
            A1: begin addr_d = pc_d[3:0];  oeb_d = 1'b0; end
            A2: begin addr_d = pc_d[7:4];  oeb_d = 1'b0; end
            A3: begin addr_d = pc_d[11:8]; oeb_d = 1'b0; end
            default: begin addr_d = '0; oeb_d = 1'b1; end
        endcase
        sync_d = (state_d == X3);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_q   <= '0;
            hi_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            rom_q   <= bus.rom_in;
            valid_q <= (state_q == X1);
            if (state_q == M2) hi_q <= rom_q;
            if (state_q == X1) instr_q <= {hi_q, rom_q};
        end
    end

    // The first X3->A1 after reset starts the first cycle rather than ending one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else if (wrap) begin
            first_q <= 1'b0;
            if (!first_q) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.phase       = state_q;
    assign bus.addr_nibble = addr_q;
    assign bus.addr_oeb    = oeb_q;
    assign bus.sync        = sync_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_rom_bus_sequencer.sv
// Directed bench for rom_bus_sequencer; a second instance with a 2-bit counter checks wrap.
module tb_rom_bus_sequencer;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  rom_bus_sequencer_if #(.CNT_W(16)) bus ();
  rom_bus_sequencer_if #(.CNT_W(2))  bus2 ();

  rom_bus_sequencer #(.CNT_W(16)) dut  (.clock(clock), .reset(reset), .bus(bus));
  rom_bus_sequencer #(.CNT_W(2))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

  assign bus2.halt   = bus.halt;
  assign bus2.pc     = bus.pc;
  assign bus2.rom_in = bus.rom_in;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.halt = 1'b0;
    bus.pc = 12'hABC;
    bus.rom_in = 4'h0;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.phase !== 3'd7 || bus.sync !== 1'b1 || bus.addr_oeb !== 1'b1 || bus.addr_nibble !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: phase=%0d sync=%b oeb=%b addr=%h, want phase=7 sync=1 oeb=1 addr=0",
               bus.phase, bus.sync, bus.addr_oeb, bus.addr_nibble);
    end
    vectors++;
    if (bus.instr !== 8'h00 || bus.instr_valid !== 1'b0 || bus.cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_data: instr=%h valid=%b cnt=%0d, want 00 0 0",
               bus.instr, bus.instr_valid, bus.cycle_count);
    end
  endtask

  task automatic test_addr_drive();
    logic [3:0] exp_a;
    logic       exp_oeb;
    logic       exp_sync;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_a    = (i == 0) ? 4'hC : (i == 1) ? 4'hB : (i == 2) ? 4'hA : 4'h0;
      exp_oeb  = (i > 2);
      exp_sync = (i == 7);
      vectors++;
      if (bus.phase !== 3'(i) || bus.addr_nibble !== exp_a || bus.addr_oeb !== exp_oeb || bus.sync !== exp_sync) begin
        miscompares++;
        $display("FAIL addr_drive step %0d: phase=%0d addr=%h oeb=%b sync=%b, want phase=%0d addr=%h oeb=%b sync=%b",
                 i, bus.phase, bus.addr_nibble, bus.addr_oeb, bus.sync, i, exp_a, exp_oeb, exp_sync);
      end
    end
    vectors++;
    if (bus.cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL first_cycle_count: got %0d want 0", bus.cycle_count);
    end
  endtask

  task automatic test_capture();
    logic [3:0] exp_a;
    logic [7:0] exp_i;
    logic       exp_v;
    bus.pc = 12'h123;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.rom_in = (i == 3) ? 4'h5 : (i == 4) ? 4'hE : 4'h0;
      exp_a = (i == 0) ? 4'h3 : (i == 1) ? 4'h2 : (i == 2) ? 4'h1 : 4'h0;
      exp_i = (i >= 6) ? 8'h5E : 8'h00;
      exp_v = (i == 6);
      vectors++;
      if (bus.addr_nibble !== exp_a || bus.instr !== exp_i || bus.instr_valid !== exp_v) begin
        miscompares++;
        $display("FAIL capture phase %0d: addr=%h instr=%h valid=%b, want addr=%h instr=%h valid=%b",
                 i, bus.addr_nibble, bus.instr, bus.instr_valid, exp_a, exp_i, exp_v);
      end
      if (i == 0) begin
        vectors++;
        if (bus.cycle_count !== 16'd1) begin
          miscompares++;
          $display("FAIL count_second_a1: got %0d want 1", bus.cycle_count);
        end
      end
    end
    // Next cycle: rom_in stays 0; instr holds 0x5E through X1, then becomes 0x00.
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_i = (i >= 6) ? 8'h00 : 8'h5E;
      exp_v = (i == 6);
      vectors++;
      if (bus.instr !== exp_i || bus.instr_valid !== exp_v) begin
        miscompares++;
        $display("FAIL instr_hold phase %0d: instr=%h valid=%b, want instr=%h valid=%b",
                 i, bus.instr, bus.instr_valid, exp_i, exp_v);
      end
      if (i == 0) begin
        vectors++;
        if (bus.cycle_count !== 16'd2) begin
          miscompares++;
          $display("FAIL count_third_a1: got %0d want 2", bus.cycle_count);
        end
      end
    end
  endtask

  task automatic test_halt();
    tick();
    for (int i = 1; i <= 3; i++) tick();
    bus.halt = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      tick();
      vectors++;
      if (bus.phase !== 3'(i)) begin
        miscompares++;
        $display("FAIL halt_ignored: phase=%0d want %0d", bus.phase, i);
      end
    end
    bus.pc = 12'h456;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.phase !== 3'd7 || bus.sync !== 1'b1 || bus.cycle_count !== 16'd3 || bus.addr_oeb !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_hold: phase=%0d sync=%b cnt=%0d oeb=%b, want 7 1 3 1",
                 bus.phase, bus.sync, bus.cycle_count, bus.addr_oeb);
      end
    end
    bus.halt = 1'b0;
    tick();
    vectors++;
    if (bus.phase !== 3'd0 || bus.addr_nibble !== 4'h6 || bus.cycle_count !== 16'd4) begin
      miscompares++;
      $display("FAIL halt_release: phase=%0d addr=%h cnt=%0d, want 0 6 4",
               bus.phase, bus.addr_nibble, bus.cycle_count);
    end
    for (int i = 1; i <= 7; i++) tick();
  endtask

  task automatic test_pc_change();
    bus.pc = 12'h789;
    tick();
    tick();
    bus.pc = 12'h000;
    tick();
    vectors++;
    if (bus.phase !== 3'd2 || bus.addr_nibble !== 4'h7 || bus.addr_oeb !== 1'b0) begin
      miscompares++;
      $display("FAIL pc_mid_cycle: phase=%0d addr=%h oeb=%b, want 2 7 0",
               bus.phase, bus.addr_nibble, bus.addr_oeb);
    end
    for (int i = 3; i <= 7; i++) tick();
    tick();
    vectors++;
    if (bus.phase !== 3'd0 || bus.addr_nibble !== 4'h0 || bus.cycle_count !== 16'd6) begin
      miscompares++;
      $display("FAIL pc_resample: phase=%0d addr=%h cnt=%0d, want 0 0 6",
               bus.phase, bus.addr_nibble, bus.cycle_count);
    end
    for (int i = 1; i <= 7; i++) tick();
  endtask

  task automatic test_wrap();
    bus.rom_in = 4'h7;
    tick();
    vectors++;
    if (bus.cycle_count !== 16'd7 || bus2.cycle_count !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_pre: cnt=%0d cnt2=%0d, want 7 3", bus.cycle_count, bus2.cycle_count);
    end
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (bus.phase !== 3'd0 || bus.cycle_count !== 16'd8 || bus2.cycle_count !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap: phase=%0d cnt=%0d cnt2=%0d, want 0 8 0",
               bus.phase, bus.cycle_count, bus2.cycle_count);
    end
    for (int i = 1; i <= 7; i++) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= 4; i++) begin
      tick();
      bus.rom_in = (i == 3) ? 4'h9 : (i == 4) ? 4'h9 : 4'h0;
    end
    vectors++;
    if (bus.phase !== 3'd4 || bus.instr !== 8'h77) begin
      miscompares++;
      $display("FAIL pre_reset: phase=%0d instr=%h, want 4 77", bus.phase, bus.instr);
    end
    #2;
    reset = 1'b1;
    bus.halt = 1'b1;
    #1;
    vectors++;
    if (bus.phase !== 3'd7 || bus.instr !== 8'h00 || bus.instr_valid !== 1'b0 || bus.sync !== 1'b1 || bus.cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset: phase=%0d instr=%h valid=%b sync=%b cnt=%0d, want 7 00 0 1 0",
               bus.phase, bus.instr, bus.instr_valid, bus.sync, bus.cycle_count);
    end
    tick();
    reset = 1'b0;
    bus.rom_in = 4'h0;
    tick();
    tick();
    vectors++;
    if (bus.phase !== 3'd7 || bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_halt: phase=%0d valid=%b, want 7 0", bus.phase, bus.instr_valid);
    end
    bus.halt = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      bus.rom_in = (i == 3) ? 4'h1 : (i == 4) ? 4'h2 : 4'h0;
      if (i == 0) begin
        vectors++;
        if (bus.cycle_count !== 16'd0) begin
          miscompares++;
          $display("FAIL reset_first_count: got %0d want 0", bus.cycle_count);
        end
      end
    end
    vectors++;
    if (bus.phase !== 3'd6 || bus.instr !== 8'h12 || bus.instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_instr: phase=%0d instr=%h valid=%b, want 6 12 1",
               bus.phase, bus.instr, bus.instr_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_addr_drive();
    test_capture();
    test_halt();
    test_pc_change();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
